// File: rtl/fetch_queue.sv
// Fetch queue between the branch predictor and decode. It holds up to QUEUE_DEPTH
// instructions in a circular buffer, accepts up to SSW per cycle and presents up to SSW per cycle.
module fetch_queue #(
  parameter int CACHE_LINE_WIDTH   = 64,
  parameter int INSTRUCTION_WIDTH  = 32,
  parameter int SUPER_SCALAR_WIDTH = 4,
  parameter int QUEUE_DEPTH        = 16,
  localparam int CNT_W = $clog2(SUPER_SCALAR_WIDTH + 1),
  localparam int OCC_W = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                                     clk_in,
  input  logic                                     rst_N_in,
  input  logic                                     flush_in,
  input  logic                                     enq_valid_in,
  output logic                                     enq_ready_out,
  input  logic [63:0]                              enq_pc_in,
  input  logic [CNT_W-1:0]                         enq_count_in,
  input  logic [CACHE_LINE_WIDTH*8-1:0]            enq_cacheline_in,
  input  logic [SUPER_SCALAR_WIDTH-1:0]            enq_pred_taken_in,
  input  logic [SUPER_SCALAR_WIDTH*64-1:0]         enq_pred_target_in,
  input  logic                                     deq_ready_in,
  output logic [CNT_W-1:0]                         deq_count_out,
  output logic [SUPER_SCALAR_WIDTH*INSTRUCTION_WIDTH-1:0] deq_instr_out,
  output logic [SUPER_SCALAR_WIDTH*64-1:0]         deq_pc_out,
  output logic [SUPER_SCALAR_WIDTH-1:0]            deq_pred_taken_out,
  output logic [SUPER_SCALAR_WIDTH*64-1:0]         deq_pred_target_out,
  output logic [OCC_W-1:0]                         occupancy_out
);

  localparam int SSW         = SUPER_SCALAR_WIDTH;
  localparam int PTR_W       = $clog2(QUEUE_DEPTH);
  localparam int OFF_W       = $clog2(CACHE_LINE_WIDTH);
  localparam int INSTR_BYTES = INSTRUCTION_WIDTH / 8;

  typedef struct packed {
    logic [INSTRUCTION_WIDTH-1:0] instr;
    logic [63:0]                  pc;
    logic                         pred_taken;
    logic [63:0]                  pred_target;
  } entry_t;

  entry_t           mem [QUEUE_DEPTH];
  entry_t           enq_entry [SSW];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [OCC_W-1:0] occ_q;
  logic [CNT_W-1:0] deq_count;
  logic [OFF_W-1:0] line_offset;
  logic             enq_fire, deq_fire, enq_legal;

  assign line_offset   = enq_pc_in[OFF_W-1:0];
  assign enq_ready_out = (occ_q <= OCC_W'(QUEUE_DEPTH - SSW)) && !flush_in;
  assign deq_count     = (occ_q >= OCC_W'(SSW)) ? CNT_W'(SSW) : CNT_W'(occ_q);
  assign enq_fire      = enq_valid_in && enq_ready_out;
  assign deq_fire      = deq_ready_in && (deq_count != '0);
  assign deq_count_out = deq_count;
  assign occupancy_out = occ_q;

  // Slot i takes INSTR_BYTES little-endian bytes starting at line offset + INSTR_BYTES*i.
  always_comb begin
    for (int i = 0; i < SSW; i++) begin
      enq_entry[i].instr = INSTRUCTION_WIDTH'(enq_cacheline_in >>
                             (8 * (int'(line_offset) + INSTR_BYTES * i)));
      enq_entry[i].pc          = enq_pc_in + 64'(INSTR_BYTES * i);
      enq_entry[i].pred_taken  = enq_pred_taken_in[i];
      enq_entry[i].pred_target = enq_pred_target_in[64*i +: 64];
    end
  end

  // NOTE: the storage array has no reset; head, tail and occupancy alone decide which entries are live.
  always_ff @(posedge clk_in) begin
    if (!rst_N_in && enq_fire) begin
      for (int i = 0; i < SSW; i++) begin
        if (i < int'(enq_count_in)) mem[tail_q + PTR_W'(i)] <= enq_entry[i];
      end
    end
  end

  // Reset and flush both empty the queue; any enqueue or dequeue that cycle is dropped.
  always_ff @(posedge clk_in) begin
    if (rst_N_in || flush_in) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      if (enq_fire) tail_q <= tail_q + PTR_W'(enq_count_in);
      if (deq_fire) head_q <= head_q + PTR_W'(deq_count);
      occ_q <= occ_q + (enq_fire ? OCC_W'(enq_count_in) : '0)
                     - (deq_fire ? OCC_W'(deq_count) : '0);
    end
  end

  always_comb begin
    // NOTE: zero defaults come first so empty slots read zero and no latch is inferred.
    deq_instr_out       = '0;
    deq_pc_out          = '0;
    deq_pred_taken_out  = '0;
    deq_pred_target_out = '0;
    for (int i = 0; i < SSW; i++) begin
      if (i < int'(deq_count)) begin
        deq_instr_out[INSTRUCTION_WIDTH*i +: INSTRUCTION_WIDTH] = mem[head_q + PTR_W'(i)].instr;
        deq_pc_out[64*i +: 64]          = mem[head_q + PTR_W'(i)].pc;
        deq_pred_taken_out[i]           = mem[head_q + PTR_W'(i)].pred_taken;
        deq_pred_target_out[64*i +: 64] = mem[head_q + PTR_W'(i)].pred_target;
      end
    end
  end

  // An accepted group must fit inside the line and within the superscalar width.
  assign enq_legal = (int'(enq_count_in) <= SSW) &&
                     (int'(line_offset) + INSTR_BYTES * int'(enq_count_in) <= CACHE_LINE_WIDTH);

  enq_group_legal: assert property (@(posedge clk_in) disable iff (rst_N_in)
                                    enq_fire |-> enq_legal);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus a randomized run, all compared
// against a queue-of-instructions reference model built straight from the byte/PC rules.
module tb_fetch_queue;

  localparam int SSW  = 4;
  localparam int QD   = 16;
  localparam int LINE = 64;

  logic         clk_in;
  logic         rst_N_in, flush_in, enq_valid_in, deq_ready_in;
  logic         enq_ready_out;
  logic [63:0]  enq_pc_in;
  logic [2:0]   enq_count_in;
  logic [511:0] enq_cacheline_in;
  logic [3:0]   enq_pred_taken_in;
  logic [255:0] enq_pred_target_in;
  logic [2:0]   deq_count_out;
  logic [127:0] deq_instr_out;
  logic [255:0] deq_pc_out;
  logic [3:0]   deq_pred_taken_out;
  logic [255:0] deq_pred_target_out;
  logic [4:0]   occupancy_out;

  fetch_queue dut (
    .clk_in              (clk_in),
    .rst_N_in            (rst_N_in),
    .flush_in            (flush_in),
    .enq_valid_in        (enq_valid_in),
    .enq_ready_out       (enq_ready_out),
    .enq_pc_in           (enq_pc_in),
    .enq_count_in        (enq_count_in),
    .enq_cacheline_in    (enq_cacheline_in),
    .enq_pred_taken_in   (enq_pred_taken_in),
    .enq_pred_target_in  (enq_pred_target_in),
    .deq_ready_in        (deq_ready_in),
    .deq_count_out       (deq_count_out),
    .deq_instr_out       (deq_instr_out),
    .deq_pc_out          (deq_pc_out),
    .deq_pred_taken_out  (deq_pred_taken_out),
    .deq_pred_target_out (deq_pred_target_out),
    .occupancy_out       (occupancy_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        taken;
    logic [63:0] target;
  } ent_t;

  ent_t mq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs: the oldest min(size, SSW) model entries, zeros elsewhere.
  task automatic check_model(input string tag);
    int           n;
    logic [127:0] ei;
    logic [255:0] ep, et;
    logic [3:0]   ek;
    logic         er;
    n  = (mq.size() < SSW) ? mq.size() : SSW;
    ei = '0; ep = '0; et = '0; ek = '0;
    for (int i = 0; i < n; i++) begin
      ei[32*i +: 32] = mq[i].instr;
      ep[64*i +: 64] = mq[i].pc;
      et[64*i +: 64] = mq[i].target;
      ek[i]          = mq[i].taken;
    end
    er = ((QD - mq.size()) >= SSW) && !flush_in;
    check({tag, ".count"},  256'(deq_count_out),      256'(n));
    check({tag, ".instr"},  256'(deq_instr_out),      256'(ei));
    check({tag, ".pc"},     deq_pc_out,               ep);
    check({tag, ".taken"},  256'(deq_pred_taken_out), 256'(ek));
    check({tag, ".target"}, deq_pred_target_out,      et);
    check({tag, ".occ"},    256'(occupancy_out),      256'(mq.size()));
    check({tag, ".ready"},  256'(enq_ready_out),      256'(er));
  endtask

  task automatic push_group();
    int         o;
    ent_t       e;
    logic [7:0] b [4];
    o = int'(enq_pc_in[5:0]);
    for (int i = 0; i < int'(enq_count_in); i++) begin
      for (int k = 0; k < 4; k++) b[k] = enq_cacheline_in[8*(o + 4*i + k) +: 8];
      e.instr  = {b[3], b[2], b[1], b[0]};
      e.pc     = enq_pc_in + 64'(4 * i);
      e.taken  = enq_pred_taken_in[i];
      e.target = enq_pred_target_in[64*i +: 64];
      mq.push_back(e);
    end
  endtask

  // Check mid-cycle, clock one edge, then update the model from the inputs seen at that edge.
  task automatic step(input string tag);
    int n;
    bit rdy;
    #2;
    check_model(tag);
    n   = (mq.size() < SSW) ? mq.size() : SSW;
    rdy = ((QD - mq.size()) >= SSW) && !flush_in;
    @(posedge clk_in);
    if (rst_N_in || flush_in) begin
      mq.delete();
    end else begin
      if (deq_ready_in && n > 0) repeat (n) void'(mq.pop_front());
      if (enq_valid_in && rdy) push_group();
    end
    #1;
  endtask

  task automatic rand_group(input int cnt);
    enq_count_in = 3'(cnt);
    enq_pc_in    = {$urandom, $urandom};
    enq_pc_in[5:0] = 6'($urandom_range(LINE - 4 * cnt, 0));
    for (int w = 0; w < 16; w++) enq_cacheline_in[32*w +: 32] = $urandom;
    enq_pred_taken_in = 4'($urandom);
    for (int w = 0; w < 8; w++) enq_pred_target_in[32*w +: 32] = $urandom;
  endtask

  task automatic ramp_line();
    for (int k = 0; k < LINE; k++) enq_cacheline_in[8*k +: 8] = 8'(k);
  endtask

  task automatic drain();
    enq_valid_in = 1'b0;
    deq_ready_in = 1'b1;
    for (int g = 0; g < 8 && mq.size() > 0; g++) step("drain");
    deq_ready_in = 1'b0;
  endtask

  initial begin
    rst_N_in = 1'b1; flush_in = 1'b0; enq_valid_in = 1'b0; deq_ready_in = 1'b0;
    enq_pc_in = '0; enq_count_in = '0; enq_cacheline_in = '0;
    enq_pred_taken_in = '0; enq_pred_target_in = '0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_N_in = 1'b0;
    mq.delete();
    step("reset");

    // Aligned full group from a ramp line.
    ramp_line(); rand_group(4); ramp_line();
    enq_pc_in = 64'h1000; enq_valid_in = 1'b1;
    step("enq_1000");
    enq_valid_in = 1'b0; #1;
    check("g1000.count", 256'(deq_count_out), 256'(4));
    check("g1000.instr0", 256'(deq_instr_out[31:0]), 256'(32'h03020100));
    check("g1000.pc3", 256'(deq_pc_out[255:192]), 256'(64'h100C));
    deq_ready_in = 1'b1; step("pop_1000"); deq_ready_in = 1'b0;

    // Two instructions ending exactly at the line boundary.
    rand_group(2); ramp_line();
    enq_pc_in = 64'h1038; enq_valid_in = 1'b1;
    step("enq_1038");
    enq_valid_in = 1'b0; #1;
    check("g1038.count", 256'(deq_count_out), 256'(2));
    check("g1038.instr1", 256'(deq_instr_out[63:32]), 256'(32'h3F3E3D3C));
    check("g1038.upper", 256'(deq_instr_out[127:64]), 256'(0));
    deq_ready_in = 1'b1; step("pop_1038"); deq_ready_in = 1'b0;

    // Fill to capacity with decode stalled; an extra offer must be refused.
    enq_valid_in = 1'b1;
    for (int g = 0; g < 4; g++) begin rand_group(4); step("fill"); end
    rand_group(4); step("full_offer");
    enq_valid_in = 1'b0; #1;
    check("full.occ", 256'(occupancy_out), 256'(16));
    check("full.ready", 256'(enq_ready_out), 256'(0));
    deq_ready_in = 1'b1; step("pop_full"); deq_ready_in = 1'b0; #1;
    check("after_pop.occ", 256'(occupancy_out), 256'(12));
    check("after_pop.ready", 256'(enq_ready_out), 256'(1));
    drain();

    // Occupancy 6, enqueue 3 while dequeuing 4.
    enq_valid_in = 1'b1;
    rand_group(3); step("pre6a");
    rand_group(3); step("pre6b");
    deq_ready_in = 1'b1; rand_group(3); step("enq3_deq4");
    enq_valid_in = 1'b0; deq_ready_in = 1'b0; #1;
    check("simul.occ", 256'(occupancy_out), 256'(5));

    // Random traffic wrapping the pointers many times.
    for (int c = 0; c < 90; c++) begin
      rand_group($urandom_range(4, 0));
      enq_valid_in = ($urandom_range(3, 0) != 0);
      deq_ready_in = ($urandom_range(2, 0) != 0);
      flush_in     = ($urandom_range(24, 0) == 0);
      step("rand");
    end
    flush_in = 1'b0;
    drain();

    // Flush at occupancy 10 with enqueue and dequeue both requested.
    enq_valid_in = 1'b1;
    rand_group(4); step("f10a");
    rand_group(4); step("f10b");
    rand_group(2); step("f10c");
    #1;
    check("pre_flush.occ", 256'(occupancy_out), 256'(10));
    rand_group(4); deq_ready_in = 1'b1; flush_in = 1'b1;
    step("flush");
    flush_in = 1'b0; deq_ready_in = 1'b0; enq_valid_in = 1'b0; #1;
    check("flush.occ", 256'(occupancy_out), 256'(0));
    check("flush.count", 256'(deq_count_out), 256'(0));
    rand_group(1); enq_pc_in = 64'h2000; enq_valid_in = 1'b1;
    step("enq_2000");
    enq_valid_in = 1'b0; #1;
    check("post_flush.pc0", 256'(deq_pc_out[63:0]), 256'(64'h2000));
    check("post_flush.count", 256'(deq_count_out), 256'(1));
    deq_ready_in = 1'b1; step("clr"); deq_ready_in = 1'b0;

    // Reset at occupancy 7 while an enqueue is offered.
    enq_valid_in = 1'b1;
    rand_group(4); step("r7a");
    rand_group(3); step("r7b");
    #1;
    check("pre_reset.occ", 256'(occupancy_out), 256'(7));
    rand_group(4); deq_ready_in = 1'b1; rst_N_in = 1'b1;
    step("reset_mid");
    rst_N_in = 1'b0; enq_valid_in = 1'b0; deq_ready_in = 1'b0; #1;
    check("rst.count", 256'(deq_count_out), 256'(0));
    check("rst.instr", 256'(deq_instr_out), 256'(0));
    check("rst.pc", deq_pc_out, 256'(0));
    check("rst.taken", 256'(deq_pred_taken_out), 256'(0));
    check("rst.target", deq_pred_target_out, 256'(0));
    check("rst.occ", 256'(occupancy_out), 256'(0));
    check("rst.ready", 256'(enq_ready_out), 256'(1));
    step("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
